tap_serializer: RTL
===================

// Module: tap_serializer
// PURPOSE
//  Consumer end of the packed parallel tap bus produced by the input sample buffer. Accepts one
//  snapshot of FILTER_LENGTH taps per valid/ready handshake, holds it, and streams the taps one per
//  handshake to the single shared complex-MAC datapath. Tap index, first and last flags accompany
//  each tap. Sits between the tap buffer and the adaptive filter MAC/update engine.
// PARAMETERS
//  FXP_WIDTH      16                     width of one signed fixed-point tap
//  FILTER_LENGTH  8                      taps per snapshot, >= 2
//  TAP_BUS_WIDTH  FXP_WIDTH*FILTER_LENGTH width of the packed input bus
//  IDX_WIDTH      $clog2(FILTER_LENGTH)  width of tap_idx
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              tap_bus holds a valid snapshot
//  in_ready   out  1              snapshot will be captured this cycle if in_valid
//  tap_bus    in   TAP_BUS_WIDTH  packed taps; tap i at [(i+1)*FXP_WIDTH-1 -: FXP_WIDTH], tap 0 newest
//  out_valid  out  1              tap_out/tap_idx/tap_first/tap_last are valid
//  out_ready  in   1              MAC accepts the current tap
//  tap_out    out  FXP_WIDTH      signed tap value
//  tap_idx    out  IDX_WIDTH      index of tap_out within the snapshot
//  tap_first  out  1              tap_idx == 0 while out_valid
//  tap_last   out  1              tap_idx == FILTER_LENGTH-1 while out_valid
//  busy       out  1              snapshot held and not fully streamed (== out_valid)
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE, snapshot register 0, tap_idx 0, out_valid 0, tap_out 0,
//    tap_first 0, tap_last 0, busy 0. in_ready reads 1 while reset is deasserted and state is IDLE.
//  - FSM: IDLE -> STREAM on capture (in_valid & in_ready). STREAM -> IDLE on the last-tap handshake
//    with no same-cycle capture. STREAM -> STREAM on last-tap handshake with same-cycle capture.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & tap_last). Combinational from out_ready;
//    no other combinational path from any input to any output.
//  - Capture: whole tap_bus registered into snapshot, tap_idx <= 0, out_valid 1 from next cycle.
//    Latency: capture edge to first tap visible = 1 cycle.
//  - Output handshake (out_valid & out_ready): tap_idx increments by 1. On the last-tap handshake,
//    tap_idx <= 0. out_valid clears unless a new snapshot is captured in the same cycle.
//  - tap_out = snapshot tap[tap_idx], bit-exact, no sign change or rescale. Outputs are stable while
//    out_valid & !out_ready. Snapshot never changes mid-stream; tap_bus changes are ignored outside
//    capture.
//  - Back-to-back: with in_valid held and out_ready held high, one tap per cycle with no bubble
//    between snapshots. Throughput is FILTER_LENGTH cycles per snapshot.
//  - Backpressure: out_ready low stalls tap_idx. in_ready stays 0 during STREAM except on the
//    last-tap handshake cycle.
//  - tap_idx never exceeds FILTER_LENGTH-1. No wrap past the last tap within one snapshot.
//  - Reset asserted mid-stream: snapshot discarded, all outputs return to reset values at once.
//    After release, wait in IDLE for a fresh capture.
// TESTING (FXP_WIDTH=16, FILTER_LENGTH=4)
//  1 Reset: rst_n=0 mid-stream at idx 2 -> out_valid=0, tap_idx=0, tap_out=0 immediately.
//    After release: in_ready=1, busy=0.
//  2 Single snapshot: tap_bus=64'h0004_0003_0002_0001, out_ready=1 -> taps 1,2,3,4 on 4
//    consecutive cycles, idx 0..3. tap_first on idx0, tap_last on idx3. Then out_valid=0.
//  3 Backpressure: out_ready=0 for 3 cycles at idx1 -> tap_out=2 and tap_idx=1 held, in_ready=0.
//    Release -> continues at 3.
//  4 Back-to-back: in_valid=1 with snapshots A, B, out_ready=1 -> 8 taps in 8 consecutive cycles.
//    in_ready pulses only on A's last tap. B idx0 directly follows A idx3.
//  5 Bus change ignored: alter tap_bus during STREAM with in_valid=1 -> streamed values equal the
//    captured snapshot.
//  6 Sign: tap value 16'h8000 at idx2 -> tap_out=16'h8000 (-32768), unchanged.

Source files
------------

// File: rtl/tap_serializer_if.sv
// Handshake bundle between the tap buffer, the tap serializer and the MAC datapath.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface tap_serializer_if #(
    parameter int FXP_WIDTH     = 16,
    parameter int FILTER_LENGTH = 8,
    parameter int TAP_BUS_WIDTH = FXP_WIDTH * FILTER_LENGTH,
    parameter int IDX_WIDTH     = $clog2(FILTER_LENGTH)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [TAP_BUS_WIDTH-1:0] tap_bus;
    logic                     out_valid;
    logic                     out_ready;
    logic [FXP_WIDTH-1:0]     tap_out;
    logic [IDX_WIDTH-1:0]     tap_idx;
    logic                     tap_first;
    logic                     tap_last;
    logic                     busy;

    modport slave (
        input  in_valid, tap_bus, out_ready,
        output in_ready, out_valid, tap_out, tap_idx, tap_first, tap_last, busy
    );

    modport master (
        output in_valid, tap_bus, out_ready,
        input  in_ready, out_valid, tap_out, tap_idx, tap_first, tap_last, busy
    );
endinterface

// File: rtl/tap_serializer.sv
// Captures one packed snapshot of FILTER_LENGTH taps and streams them, one per handshake,
// to the shared complex-MAC datapath with index and first/last markers.
module tap_serializer #(
    parameter int FXP_WIDTH     = 16,
    parameter int FILTER_LENGTH = 8,
    parameter int TAP_BUS_WIDTH = FXP_WIDTH * FILTER_LENGTH,
    parameter int IDX_WIDTH     = $clog2(FILTER_LENGTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    tap_serializer_if.slave bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FILTER_LENGTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [FXP_WIDTH-1:0] taps [FILTER_LENGTH];
    logic [IDX_WIDTH-1:0] idx_q;
    logic [IDX_WIDTH-1:0] idx_next;
    logic [FXP_WIDTH-1:0] tap_out_q;
    logic                 out_valid_q;
    logic                 first_q;
    logic                 last_q;
    logic                 in_ready;
    logic                 handshake;
    logic                 capture;

    // The only combinational input-to-output path: a new snapshot may enter on the last-tap handshake.
    assign handshake = out_valid_q & bus.out_ready;
    assign in_ready  = (state == IDLE) | (handshake & last_q);
    assign capture   = bus.in_valid & in_ready;
    assign idx_next  = idx_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx_q       <= '0;
            tap_out_q   <= '0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            // NOTE: the snapshot is a handful of flops, not a RAM, so clearing it on reset is cheap and intended.
            for (int i = 0; i < FILTER_LENGTH; i++) taps[i] <= '0;
        end else if (capture) begin
            state       <= STREAM;
            idx_q       <= '0;
            tap_out_q   <= bus.tap_bus[FXP_WIDTH-1:0];
            out_valid_q <= 1'b1;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            for (int i = 0; i < FILTER_LENGTH; i++) taps[i] <= bus.tap_bus[i*FXP_WIDTH +: FXP_WIDTH];
        end else if (handshake) begin
            if (last_q) begin
                state       <= IDLE;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                first_q     <= 1'b0;
                last_q      <= 1'b0;
            end else begin
                idx_q     <= idx_next;
                tap_out_q <= taps[idx_next];
                first_q   <= 1'b0;
                last_q    <= (idx_next == LAST_IDX);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.tap_out   = tap_out_q;
    assign bus.tap_idx   = idx_q;
    assign bus.tap_first = first_q;
    assign bus.tap_last  = last_q;
    assign bus.busy      = out_valid_q;
endmodule
